// File: rtl/cmsdk_ahb_slave_error_resp_if.sv
// cmsdk_ahb_slave_error_resp_if: AHB-Lite slave-side bus signals seen by the error response engine.
interface cmsdk_ahb_slave_error_resp_if #(
   parameter int ADDR_W = 32
);
   logic              HSELS;
   logic [1:0]        HTRANSS;
   logic              HWRITES;
   logic [ADDR_W-1:0] HADDRS;
   logic              HREADYS;
   logic              HREADYOUTS;
   logic              HRESPS;
   modport master (output HSELS, HTRANSS, HWRITES, HADDRS, HREADYS, input HREADYOUTS, HRESPS);
   modport slave (input HSELS, HTRANSS, HWRITES, HADDRS, HREADYS, output HREADYOUTS, HRESPS);
endinterface

// File: rtl/cmsdk_ahb_slave_error_resp.sv
// cmsdk_ahb_slave_error_resp: AHB-Lite responder turning backend done/err into OKAY/ERROR and cancelling
// the remaining SEQ beats of an errored burst; WAIT timeout enabled by CMSDK_AHB_SLAVE_ERROR_RESP_TIMEOUT_EN.
module cmsdk_ahb_slave_error_resp #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                        HCLK,
   input  logic                        HRESET,
   cmsdk_ahb_slave_error_resp_if.slave ahb,
   output logic                        req_valid,
   output logic                        req_write,
   output logic [ADDR_W-1:0]           req_addr,
   output logic                        req_abort,
   input  logic                        rsp_done,
   input  logic                        rsp_err
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
   state_t state, state_nx;
   logic burst_err, ready, accept, issue, cancel, fail, timeout;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 2..256");
   end

   always_comb begin
      ready    = (state == S_IDLE) || (state == S_ERR2) || (state == S_WAIT && rsp_done && !rsp_err);
      accept   = ahb.HSELS && ahb.HREADYS && ahb.HTRANSS[1] && ready;
      issue    = accept && (!ahb.HTRANSS[0] || !burst_err);
      cancel   = accept && ahb.HTRANSS[0] && burst_err;
      fail     = (state == S_WAIT && rsp_done && rsp_err) || timeout;
      state_nx = (state == S_ERR1) ? S_ERR2 :
                 fail              ? S_ERR1 :
                 issue             ? S_WAIT :
                 cancel            ? S_ERR1 :
                 ready             ? S_IDLE : state;
   end

   assign ahb.HREADYOUTS = ready;
   assign ahb.HRESPS     = (state == S_ERR1) || (state == S_ERR2);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= S_IDLE;
         burst_err <= 1'b0;
         req_valid <= 1'b0;
         req_write <= 1'b0;
         req_addr  <= '0;
      end else begin
         state     <= state_nx;
         req_valid <= issue;
         // IDLE/NONSEQ ends a burst; BUSY keeps it alive
         if (fail)
            burst_err <= 1'b1;
         else if (ahb.HREADYS && !ahb.HTRANSS[0])
            burst_err <= 1'b0;
         if (issue) begin
            req_write <= ahb.HWRITES;
            req_addr  <= ahb.HADDRS;
         end
      end
   end

`ifdef CMSDK_AHB_SLAVE_ERROR_RESP_TIMEOUT_EN
   logic [7:0] cnt;
   assign timeout = (state == S_WAIT) && !rsp_done && (cnt == 8'(TIMEOUT_CYCLES - 1));
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         cnt       <= '0;
         req_abort <= 1'b0;
      end else begin
         cnt       <= issue ? 8'd0 : (state == S_WAIT && !rsp_done) ? cnt + 8'd1 : cnt;
         req_abort <= timeout;
      end
   end
`else
   assign timeout   = 1'b0;
   assign req_abort = 1'b0;
`endif
endmodule

// File: tb/tb_cmsdk_ahb_slave_error_resp.sv
// tb_cmsdk_ahb_slave_error_resp: directed and random AHB transfers against a transfer-level response model.
module tb_cmsdk_ahb_slave_error_resp;
   localparam int TO = 4;
   typedef struct {
      bit        sel;
      bit [1:0]  trans;
      bit        write;
      bit [31:0] addr;
      int        lat;
      bit        err;
   } xfer_t;

   logic        HCLK = 1'b0, HRESET = 1'b1;
   logic        req_valid, req_write, req_abort;
   logic [31:0] req_addr;
   logic        rsp_done = 1'b0, rsp_err = 1'b0;
   int          checks = 0, errors = 0, pulses = 0;
   bit          berr = 1'b0;

   cmsdk_ahb_slave_error_resp_if #(.ADDR_W(32)) bus ();
   assign bus.HREADYS = bus.HREADYOUTS;

   cmsdk_ahb_slave_error_resp #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .ahb(bus),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_abort(req_abort),
      .rsp_done(rsp_done), .rsp_err(rsp_err)
   );

   always #5 HCLK = ~HCLK;
   always @(negedge HCLK) if (req_valid === 1'b1) pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic xfer_t mk(bit sel, bit [1:0] trans, bit write, bit [31:0] addr, int lat, bit err);
      mk = '{sel, trans, write, addr, lat, err};
   endfunction

   task automatic drive(input xfer_t x);
      bus.HSELS   = x.sel;
      bus.HTRANSS = x.trans;
      bus.HWRITES = x.write;
      bus.HADDRS  = x.addr;
   endtask

   task automatic rnd_rsp();
      rsp_done = 1'($urandom);
      rsp_err  = 1'($urandom);
   endtask

   task automatic outs(input string tag, input bit rdy, input bit resp, input bit abort);
      check({tag, "_rdy"}, bus.HREADYOUTS, rdy);
      check({tag, "_resp"}, bus.HRESPS, resp);
      check({tag, "_abort"}, req_abort, abort);
      check({tag, "_rv"}, req_valid, 0);
   endtask

   task automatic err_pair(input bit abort, input bit now);
      if (!now) begin @(posedge HCLK); #1; end
      rnd_rsp();
      @(negedge HCLK) outs("err1", 0, 1, abort);
      @(posedge HCLK); #1;
      rnd_rsp();
      @(negedge HCLK) outs("err2", 1, 1, 0);
   endtask

   task automatic run(input xfer_t q[$]);
      drive(q[0]);
      foreach (q[i]) begin
         automatic xfer_t x = q[i];
         automatic int act, stop;
         automatic bit to;
         @(posedge HCLK); #1;
         act = (!x.sel || !x.trans[1]) ? 0 : (!x.trans[0] || !berr) ? 1 : 2;
         if (!x.trans[0]) berr = 0;
         drive(i + 1 < q.size() ? q[i+1] : mk(1, 2'b01, 0, 0, 0, 0));
         if (act == 0) begin
            rnd_rsp();
            @(negedge HCLK) outs("zw", 1, 0, 0);
         end else if (act == 2) begin
            err_pair(0, 1);
         end else begin
            stop = x.lat;
            to   = 0;
`ifdef CMSDK_AHB_SLAVE_ERROR_RESP_TIMEOUT_EN
            if (x.lat > TO - 1) begin stop = TO - 1; to = 1; end
`endif
            for (int k = 0; k <= stop; k++) begin
               if (k > 0) begin @(posedge HCLK); #1; end
               rsp_done = (k == x.lat);
               rsp_err  = (k == x.lat) ? x.err : 1'($urandom);
               @(negedge HCLK);
               check("rv", req_valid, k == 0);
               if (k == 0) begin
                  check("addr", req_addr, x.addr);
                  check("write", req_write, x.write);
               end
               check("wait_rdy", bus.HREADYOUTS, k == x.lat && !x.err);
               check("wait_resp", bus.HRESPS, 0);
               check("wait_abort", req_abort, 0);
            end
            if (to || x.err) begin
               err_pair(to, 0);
               berr = 1;
            end
         end
      end
   endtask

   initial begin
      xfer_t q[$];
      int p0;
      drive(mk(0, 2'b00, 0, 0, 0, 0));
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      check("rst_rdy", bus.HREADYOUTS, 1);
      check("rst_resp", bus.HRESPS, 0);
      check("rst_rv", req_valid, 0);
      check("rst_write", req_write, 0);
      check("rst_addr", req_addr, 0);
      check("rst_abort", req_abort, 0);
      @(posedge HCLK); #1;
      HRESET = 0;
      run('{mk(1, 2'b10, 1, 32'h40, 3, 0)});
      run('{mk(1, 2'b10, 0, 32'h44, 1, 1)});
      p0 = pulses;
      run('{mk(1, 2'b10, 1, 32'h100, 2, 0), mk(1, 2'b11, 1, 32'h104, 1, 1),
            mk(1, 2'b11, 1, 32'h108, 2, 0), mk(1, 2'b11, 1, 32'h10c, 2, 0)});
      check("incr4_pulses", pulses - p0, 2);
      run('{mk(1, 2'b10, 0, 32'h200, 1, 1), mk(1, 2'b01, 0, 32'h204, 0, 0),
            mk(1, 2'b10, 0, 32'h300, 2, 0)});
      run('{mk(1, 2'b10, 1, 32'h80, 10, 0)});
      for (int n = 0; n < 60; n++)
         q.push_back(mk($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), $urandom & 32'hffff_fffc,
                        $urandom_range(1, 5), $urandom_range(0, 3) == 0));
      run(q);
      drive(mk(1, 2'b10, 1, 32'h500, 0, 0));
      @(posedge HCLK); #1;
      drive(mk(1, 2'b01, 0, 0, 0, 0));
      rsp_done = 1; rsp_err = 1; HRESET = 1;
      @(posedge HCLK); #1;
      HRESET = 0; rsp_done = 0; rsp_err = 0;
      @(negedge HCLK) outs("wait_rst", 1, 0, 0);
      berr = 0;
      run('{mk(1, 2'b10, 0, 32'h600, 1, 1)});
      HRESET = 1;
      @(posedge HCLK); #1;
      HRESET = 0;
      berr = 0;
      run('{mk(1, 2'b11, 1, 32'h700, 2, 0)});
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
